// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one outstanding load/store, IDLE -> ACCESS -> RESP.
// Build option: define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic [31:0] rd_word;

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          range_err;
    logic          size_err;
    logic          misalign_err;
    logic          acc_err;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_rep;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output and next-state is defaulted first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request fields only load on an accept; reset blocks a concurrent accept.
    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && req_valid) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
        end
    end

    assign word_idx  = r_addr[AW+1:2];
    assign lane      = r_addr[1:0];
    assign range_err = |(r_addr >> (AW + 2));
    assign size_err  = (r_size == 2'b11);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_err = ((r_size == 2'b01) && r_addr[0]) ||
                          ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
`else
    // Lane selection below ignores the offending low bits, which forces alignment.
    assign misalign_err = 1'b0;
`endif

    assign acc_err = range_err | size_err | misalign_err;

    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = r_wdata;
        case (r_size)
            2'b00: begin
                byte_en   = 4'b0001 << lane;
                wdata_rep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                wdata_rep = r_wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_rep = r_wdata;
            end
        endcase
    end

    // NOTE: the array has no reset term; only the write enable looks at reset so a
    // reset edge in ACCESS drops the store, while contents stay as written.
    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS && r_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
        if (state == ACCESS) begin
            rd_word <= mem[word_idx];
        end
    end

    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (r_size)
            2'b00:   load_data = r_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = r_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // Response fields are held by the registered request, so they stay stable in RESP.
    assign rsp_rdata = (state == RESP && !r_we && !acc_err) ? load_data : 32'h0;
    assign rsp_err   = (state == RESP) && acc_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus reset/backpressure sequences.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_responder #(.DEPTH_WORDS(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    // Full transaction: accept, measure latency, optionally stall rsp_ready, then handshake.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input int hold,
                       input string tag, output logic [31:0] rdata, output logic err);
        int lat;
        @(negedge clk);
        check({tag, " req_ready before accept"}, {31'b0, req_ready}, 32'd1);
        req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " response latency"}, lat, 32'd2);
        rdata = rsp_rdata;
        err   = rsp_err;
        if (rsp_valid) begin
            for (int i = 0; i < hold; i++) begin
                check({tag, " stall rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
                check({tag, " stall rsp_rdata"}, rsp_rdata, rdata);
                check({tag, " stall rsp_err"}, {31'b0, rsp_err}, {31'b0, err});
                check({tag, " stall req_ready"}, {31'b0, req_ready}, 32'd0);
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            check({tag, " req_ready after handshake"}, {31'b0, req_ready}, 32'd1);
            check({tag, " rsp_valid after handshake"}, {31'b0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        string       tag;

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'h0; req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset req_ready", {31'b0, req_ready}, 32'd1);

        add(1, 32'h10,  2'b10, 0, 32'hDEADBEEF, 32'h0,        0);
        add(0, 32'h10,  2'b10, 0, 32'h0,        32'hDEADBEEF, 0);
        add(0, 32'h10,  2'b10, 1, 32'h0,        32'hDEADBEEF, 0);
        add(1, 32'h20,  2'b10, 0, 32'h0,        32'h0,        0);
        add(1, 32'h21,  2'b00, 0, 32'h80,       32'h0,        0);
        add(0, 32'h21,  2'b00, 0, 32'h0,        32'hFFFFFF80, 0);
        add(0, 32'h21,  2'b00, 1, 32'h0,        32'h00000080, 0);
        add(0, 32'h20,  2'b10, 0, 32'h0,        32'h00008000, 0);
        add(1, 32'h22,  2'b00, 0, 32'h12345677, 32'h0,        0);
        add(0, 32'h20,  2'b10, 0, 32'h0,        32'h00778000, 0);
        add(0, 32'h22,  2'b01, 1, 32'h0,        32'h00000077, 0);
        add(0, 32'h20,  2'b01, 0, 32'h0,        32'hFFFF8000, 0);
        add(0, 32'h12,  2'b01, 0, 32'h0,        32'hFFFFDEAD, 0);
        add(0, 32'h12,  2'b01, 1, 32'h0,        32'h0000DEAD, 0);
        add(0, 32'h10,  2'b01, 0, 32'h0,        32'hFFFFBEEF, 0);
        add(0, 32'h13,  2'b00, 1, 32'h0,        32'h000000DE, 0);
        add(0, 32'h10,  2'b00, 0, 32'h0,        32'hFFFFFFEF, 0);
        add(1, 32'h0,   2'b10, 0, 32'h11223344, 32'h0,        0);
        add(1, 32'h1000, 2'b10, 0, 32'hFFFFFFFF, 32'h0,       1);
        add(0, 32'h1000, 2'b10, 0, 32'h0,       32'h0,        1);
        add(0, 32'h80000000, 2'b10, 0, 32'h0,   32'h0,        1);
        add(0, 32'h0,   2'b10, 0, 32'h0,        32'h11223344, 0);
        add(1, 32'h0,   2'b11, 0, 32'hAAAAAAAA, 32'h0,        1);
        add(0, 32'h0,   2'b11, 0, 32'h0,        32'h0,        1);
        add(0, 32'h0,   2'b10, 0, 32'h0,        32'h11223344, 0);
        add(1, 32'hFFC, 2'b10, 0, 32'hCAFEF00D, 32'h0,        0);
        add(0, 32'hFFC, 2'b10, 0, 32'h0,        32'hCAFEF00D, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        add(1, 32'h3,   2'b01, 0, 32'hABCD,     32'h0,        1);
        add(0, 32'h0,   2'b10, 0, 32'h0,        32'h11223344, 0);
        add(0, 32'h11,  2'b10, 0, 32'h0,        32'h0,        1);
        add(0, 32'h11,  2'b01, 0, 32'h0,        32'h0,        1);
`else
        add(1, 32'h3,   2'b01, 0, 32'hABCD,     32'h0,        0);
        add(0, 32'h0,   2'b10, 0, 32'h0,        32'hABCD3344, 0);
        add(0, 32'h11,  2'b10, 0, 32'h0,        32'hDEADBEEF, 0);
        add(0, 32'h11,  2'b01, 0, 32'h0,        32'hFFFFBEEF, 0);
`endif

        foreach (vecs[i]) begin
            tag = $sformatf("vec%0d", i);
            txn(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, 0, tag, rd, er);
            check({tag, " rdata"}, rd, vecs[i].exp_rdata);
            check({tag, " err"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
        end

        // Backpressure: hold rsp_ready low for 5 cycles on a load.
        txn(0, 32'h10, 2'b10, 0, 32'h0, 5, "bp", rd, er);
        check("bp rdata", rd, 32'hDEADBEEF);
        check("bp err", {31'b0, er}, 32'd0);

        // Reset during ACCESS of a store drops the write and the response.
        txn(1, 32'h40, 2'b10, 0, 32'h55AA55AA, 0, "pre40", rd, er);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_access req_ready", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rst_access no response", {31'b0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        txn(0, 32'h40, 2'b10, 0, 32'h0, 0, "rst_access lw", rd, er);
        check("rst_access prior value", rd, 32'h55AA55AA);

        // Reset during RESP drops the pending response.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h40; req_size = 2'b10;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_resp in RESP", {31'b0, rsp_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_resp dropped", {31'b0, rsp_valid}, 32'd0);
        check("rst_resp rdata", rsp_rdata, 32'd0);
        check("rst_resp req_ready", {31'b0, req_ready}, 32'd1);

        // Reset in IDLE wins over a concurrent request.
        txn(1, 32'h44, 2'b10, 0, 32'h0A0B0C0D, 0, "pre44", rd, er);
        @(negedge clk);
        reset = 1'b1;
        req_we = 1'b1; req_addr = 32'h44; req_size = 2'b10; req_wdata = 32'hBAD0BAD0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_idle no response", {31'b0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        txn(0, 32'h44, 2'b10, 0, 32'h0, 0, "rst_idle lw", rd, er);
        check("rst_idle prior value", rd, 32'h0A0B0C0D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
